// File: rtl/regfile_mp_sb.sv
// Multi-ported integer register file with an integrated busy-bit scoreboard.
// NRD combinational read ports, two posedge write-back ports (ALU = wb0,
// LSU = wb1), optional same-cycle write bypass, x0 hardwired to zero and
// x2 (sp) reset to SP_INIT. Busy bits are set at issue and cleared at
// write-back so decode can stall on RAW hazards.
module regfile_mp_sb #(
  parameter int               WIDTH   = 32,
  parameter int               ADDR    = 5,
  parameter int               NRD     = 3,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'('h8000),
  parameter bit               BYPASS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NRD*ADDR-1:0]   rs_addr,
  output logic [NRD*WIDTH-1:0]  rs_data,
  output logic [NRD-1:0]        rs_busy,
  input  logic                  iss_valid,
  input  logic [ADDR-1:0]       iss_rd,
  input  logic                  wb0_en,
  input  logic [ADDR-1:0]       wb0_rd,
  input  logic [WIDTH-1:0]      wb0_data,
  input  logic                  wb1_en,
  input  logic [ADDR-1:0]       wb1_rd,
  input  logic [WIDTH-1:0]      wb1_data,
  input  logic                  flush,
  output logic [(2**ADDR)-1:0]  busy_vec
);

  localparam int NREG = 2 ** ADDR;

  // Storage and scoreboard state. Entry 0 of the array is never written
  // after reset, and reads of address 0 are forced to zero anyway.
  logic [WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]  r_busy;

  logic [NREG-1:0]  w_busyNext;
  logic [ADDR-1:0]  w_rsAddr [NRD];
  logic             w_wb0Live;
  logic             w_wb1Live;
  logic             w_issLive;

  // A write-back or issue aimed at x0 has no architectural effect, so it is
  // filtered out once here and every consumer sees only "live" requests.
  assign w_wb0Live = wb0_en    && (wb0_rd != '0);
  assign w_wb1Live = wb1_en    && (wb1_rd != '0);
  assign w_issLive = iss_valid && (iss_rd != '0);

  // Register array: reset image, then ALU and LSU write-backs. The LSU write
  // is placed second so it overrides the ALU when both target one register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else begin
      if (w_wb0Live) begin
        r_regs[wb0_rd] <= wb0_data;
      end
      if (w_wb1Live) begin
        r_regs[wb1_rd] <= wb1_data;
      end
    end
  end

  // Scoreboard next state: flush clears everything, a new issue beats a
  // same-cycle write-back (the issuing instruction is the younger producer),
  // and a write-back on either port retires the pending producer.
  always_comb begin
    w_busyNext = r_busy;
    for (int r = 1; r < NREG; r++) begin
      if (flush) begin
        w_busyNext[r] = 1'b0;
      end else if (w_issLive && (iss_rd == ADDR'(r))) begin
        w_busyNext[r] = 1'b1;
      end else if ((w_wb0Live && (wb0_rd == ADDR'(r))) ||
                   (w_wb1Live && (wb1_rd == ADDR'(r)))) begin
        w_busyNext[r] = 1'b0;
      end
    end
    w_busyNext[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  // Split the flat read-address bus into one address per port.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_rsAddr[k] = rs_addr[k*ADDR +: ADDR];
    end
  end

  // Read ports: x0 reads zero; with bypass the LSU write-back has priority
  // over the ALU write-back, which has priority over the stored array.
  // Busy reflects registered state only, even when a write-back to the same
  // register is in flight this cycle.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_rsAddr[k] == '0) begin
        rs_data[k*WIDTH +: WIDTH] = '0;
      end else if (BYPASS && w_wb1Live && (wb1_rd == w_rsAddr[k])) begin
        rs_data[k*WIDTH +: WIDTH] = wb1_data;
      end else if (BYPASS && w_wb0Live && (wb0_rd == w_rsAddr[k])) begin
        rs_data[k*WIDTH +: WIDTH] = wb0_data;
      end else begin
        rs_data[k*WIDTH +: WIDTH] = r_regs[w_rsAddr[k]];
      end
      rs_busy[k] = r_busy[w_rsAddr[k]];
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb. Two instances share all inputs:
// dutA is built with BYPASS=1, dutB with BYPASS=0. Stimulus pushes
// hand-computed expectations into a queue; a monitor on the falling edge
// pops them and compares against the live DUT outputs.
module tb_regfile_mp_sb;

   localparam int WIDTH = 32;
   localparam int ADDR  = 5;
   localparam int NRD   = 3;
   localparam int NREG  = 2 ** ADDR;

   localparam logic [2:0] K_A_DATA = 3'd0;
   localparam logic [2:0] K_A_BUSY = 3'd1;
   localparam logic [2:0] K_A_VEC  = 3'd2;
   localparam logic [2:0] K_B_DATA = 3'd3;
   localparam logic [2:0] K_B_VEC  = 3'd4;

   typedef struct packed {
      logic [2:0]  kind;
      logic [1:0]  idx;
      logic [31:0] value;
   } expT;

   logic                 clk;
   logic                 reset_n;
   logic [NRD*ADDR-1:0]  rsAddr;
   logic [NRD*WIDTH-1:0] aRsData;
   logic [NRD*WIDTH-1:0] bRsData;
   logic [NRD-1:0]       aRsBusy;
   logic [NRD-1:0]       bRsBusy;
   logic                 issValid;
   logic [ADDR-1:0]      issRd;
   logic                 wb0En;
   logic [ADDR-1:0]      wb0Rd;
   logic [WIDTH-1:0]     wb0Data;
   logic                 wb1En;
   logic [ADDR-1:0]      wb1Rd;
   logic [WIDTH-1:0]     wb1Data;
   logic                 flushIn;
   logic [NREG-1:0]      aBusyVec;
   logic [NREG-1:0]      bBusyVec;

   expT   expQ[$];
   string nameQ[$];
   int    testsRun;
   int    testsFailed;
   bit    doneFlag;

   regfile_mp_sb #(.WIDTH(WIDTH), .ADDR(ADDR), .NRD(NRD), .BYPASS(1'b1)) dutA (
      .clk(clk), .reset_n(reset_n), .rs_addr(rsAddr), .rs_data(aRsData),
      .rs_busy(aRsBusy), .iss_valid(issValid), .iss_rd(issRd),
      .wb0_en(wb0En), .wb0_rd(wb0Rd), .wb0_data(wb0Data),
      .wb1_en(wb1En), .wb1_rd(wb1Rd), .wb1_data(wb1Data),
      .flush(flushIn), .busy_vec(aBusyVec)
   );

   regfile_mp_sb #(.WIDTH(WIDTH), .ADDR(ADDR), .NRD(NRD), .BYPASS(1'b0)) dutB (
      .clk(clk), .reset_n(reset_n), .rs_addr(rsAddr), .rs_data(bRsData),
      .rs_busy(bRsBusy), .iss_valid(issValid), .iss_rd(issRd),
      .wb0_en(wb0En), .wb0_rd(wb0Rd), .wb0_data(wb0Data),
      .wb1_en(wb1En), .wb1_rd(wb1Rd), .wb1_data(wb1Data),
      .flush(flushIn), .busy_vec(bBusyVec)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog: if the stimulus sequence has not completed within a bounded
   // time the wait has expired, which is reported as a failure.
   initial begin
      #100000;
      if (!doneFlag) begin
         testsFailed++;
         $display("[TB] FAIL timeout: stimulus did not complete");
         $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
         $finish;
      end
   end

   function automatic logic [31:0] pickActual(input logic [2:0] kind, input logic [1:0] idx);
      case (kind)
         K_A_DATA: pickActual = aRsData[idx*WIDTH +: WIDTH];
         K_A_BUSY: pickActual = {31'd0, aRsBusy[idx]};
         K_A_VEC:  pickActual = aBusyVec;
         K_B_DATA: pickActual = bRsData[idx*WIDTH +: WIDTH];
         K_B_VEC:  pickActual = bBusyVec;
         default:  pickActual = 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: on every falling edge drain the expectations queued for this
   // cycle and compare each against the DUT output it names.
   always @(negedge clk) begin
      expT         e;
      string       nm;
      logic [31:0] act;
      while (expQ.size() > 0) begin
         e   = expQ.pop_front();
         nm  = nameQ.pop_front();
         act = pickActual(e.kind, e.idx);
         testsRun++;
         if (act !== e.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, e.value);
         end
      end
   end

   // Queue an expectation to be compared by the monitor at the next falling
   // edge.
   task automatic checkOutput(input string nm, input logic [2:0] kind,
                              input logic [1:0] idx, input logic [31:0] value);
      expT e;
      e.kind  = kind;
      e.idx   = idx;
      e.value = value;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   // Compare an output immediately, without waiting for any clock edge.
   task automatic checkNow(input string nm, input logic [2:0] kind,
                           input logic [1:0] idx, input logic [31:0] value);
      logic [31:0] act;
      act = pickActual(kind, idx);
      testsRun++;
      if (act !== value) begin
         testsFailed++;
         $display("[TB] FAIL %s (immediate): got %h, expected %h", nm, act, value);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [ADDR-1:0] ir,
                                input logic w0e, input logic [ADDR-1:0] w0r, input logic [31:0] w0d,
                                input logic w1e, input logic [ADDR-1:0] w1r, input logic [31:0] w1d,
                                input logic fl,
                                input logic [ADDR-1:0] a0, input logic [ADDR-1:0] a1,
                                input logic [ADDR-1:0] a2);
      issValid = iv;  issRd = ir;
      wb0En    = w0e; wb0Rd = w0r; wb0Data = w0d;
      wb1En    = w1e; wb1Rd = w1r; wb1Data = w1d;
      flushIn  = fl;
      rsAddr   = {a2, a1, a0};
   endtask

   task automatic idle(input logic [ADDR-1:0] a0, input logic [ADDR-1:0] a1,
                       input logic [ADDR-1:0] a2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1, a2);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Main stimulus sequence.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      doneFlag    = 1'b0;
      reset_n     = 1'b0;
      idle(2, 5, 0);
      nextCycle();

      checkOutput("rst_x2",   K_A_DATA, 0, 32'h8000);
      checkOutput("rst_x5",   K_A_DATA, 1, 32'h0);
      checkOutput("rst_x0",   K_A_DATA, 2, 32'h0);
      checkOutput("rst_vec",  K_A_VEC,  0, 32'h0);
      checkOutput("rst_x2_b", K_B_DATA, 0, 32'h8000);
      nextCycle();
      reset_n = 1'b1;
      nextCycle();

      applyStimulus(0, 0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 7, 0, 0);
      checkOutput("coll_byp",   K_A_DATA, 0, 32'h22);
      checkOutput("coll_nobyp", K_B_DATA, 0, 32'h0);
      nextCycle();
      idle(7, 0, 0);
      checkOutput("coll_next_a", K_A_DATA, 0, 32'h22);
      checkOutput("coll_next_b", K_B_DATA, 0, 32'h22);
      nextCycle();

      applyStimulus(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_wr_byp", K_A_DATA, 0, 32'h0);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_rd_a", K_A_DATA, 0, 32'h0);
      checkOutput("x0_rd_b", K_B_DATA, 0, 32'h0);
      nextCycle();
      idle(0, 0, 0);
      checkOutput("x0_vec",  K_A_VEC,  0, 32'h0);
      checkOutput("x0_busy", K_A_BUSY, 0, 32'h0);
      nextCycle();

      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
      checkOutput("sb_iss_same", K_A_BUSY, 0, 32'h0);
      nextCycle();
      idle(9, 0, 0);
      checkOutput("sb_iss_busy", K_A_BUSY, 0, 32'h1);
      checkOutput("sb_iss_vec",  K_A_VEC,  0, 32'h0000_0200);
      nextCycle();
      applyStimulus(1, 9, 1, 9, 32'h99, 0, 0, 0, 0, 9, 0, 0);
      checkOutput("sb_wb0_byp", K_A_DATA, 0, 32'h99);
      nextCycle();
      idle(9, 0, 0);
      checkOutput("sb_iss_wins", K_A_BUSY, 0, 32'h1);
      checkOutput("sb_x9_a",     K_A_DATA, 0, 32'h99);
      checkOutput("sb_x9_b",     K_B_DATA, 0, 32'h99);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'h77, 0, 9, 0, 0);
      checkOutput("sb_wb1_hold", K_A_BUSY, 0, 32'h1);
      checkOutput("sb_wb1_byp",  K_A_DATA, 0, 32'h77);
      checkOutput("sb_wb1_old",  K_B_DATA, 0, 32'h99);
      nextCycle();
      idle(9, 0, 0);
      checkOutput("sb_clear",     K_A_BUSY, 0, 32'h0);
      checkOutput("sb_clear_vec", K_A_VEC,  0, 32'h0);
      checkOutput("sb_x9_new",    K_A_DATA, 0, 32'h77);
      nextCycle();

      applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("fl_vec_3", K_A_VEC, 0, 32'h0000_0008);
      nextCycle();
      applyStimulus(0, 0, 1, 3, 32'h55, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("fl_vec_34", K_A_VEC, 0, 32'h0000_0018);
      nextCycle();
      idle(3, 4, 2);
      checkOutput("fl_vec_a", K_A_VEC,  0, 32'h0);
      checkOutput("fl_vec_b", K_B_VEC,  0, 32'h0);
      checkOutput("fl_x3",    K_A_DATA, 0, 32'h55);
      checkOutput("fl_x4",    K_A_DATA, 1, 32'h44);
      checkOutput("fl_x2",    K_A_DATA, 2, 32'h8000);
      nextCycle();

      applyStimulus(0, 0, 1, 10, 32'hAB, 0, 0, 0, 0, 10, 7, 2);
      checkOutput("nb_p0_old", K_B_DATA, 0, 32'h0);
      checkOutput("nb_p1",     K_B_DATA, 1, 32'h22);
      checkOutput("nb_p2",     K_B_DATA, 2, 32'h8000);
      checkOutput("nb_p0_byp", K_A_DATA, 0, 32'hAB);
      nextCycle();
      idle(10, 7, 2);
      checkOutput("nb_p0_new", K_B_DATA, 0, 32'hAB);
      checkOutput("nb_p1_new", K_B_DATA, 1, 32'h22);
      checkOutput("nb_p2_new", K_B_DATA, 2, 32'h8000);
      nextCycle();

      applyStimulus(1, 11, 1, 2, 32'h1234, 0, 0, 0, 0, 2, 5, 7);
      nextCycle();
      idle(2, 5, 7);
      checkOutput("pre_x2",  K_A_DATA, 0, 32'h1234);
      checkOutput("pre_vec", K_A_VEC,  0, 32'h0000_0800);
      nextCycle();
      reset_n = 1'b0;
      #1;
      checkNow("imm_rst_x2",    K_A_DATA, 0, 32'h8000);
      checkNow("imm_rst_x5",    K_A_DATA, 1, 32'h0);
      checkNow("imm_rst_x7",    K_A_DATA, 2, 32'h0);
      checkNow("imm_rst_vec",   K_A_VEC,  0, 32'h0);
      checkNow("imm_rst_vec_b", K_B_VEC,  0, 32'h0);
      checkOutput("mrst_x2",    K_A_DATA, 0, 32'h8000);
      checkOutput("mrst_x5",    K_A_DATA, 1, 32'h0);
      checkOutput("mrst_x7",    K_A_DATA, 2, 32'h0);
      checkOutput("mrst_vec",   K_A_VEC,  0, 32'h0);
      checkOutput("mrst_x2_b",  K_B_DATA, 0, 32'h8000);
      checkOutput("mrst_vec_b", K_B_VEC,  0, 32'h0);
      nextCycle();
      reset_n = 1'b1;
      nextCycle();
      checkOutput("post_x2", K_A_DATA, 0, 32'h8000);
      nextCycle();
      nextCycle();

      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL %0d expectations never compared", expQ.size());
      end
      doneFlag = 1'b1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
